// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_mc_pkg;

  // Controller states; S_EXECM only exists when the multiply extension is built in.
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWRITE = 5'd4,
    S_MEMWB    = 5'd5,
    S_EXECR    = 5'd6,
    S_EXECI    = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9,
    S_JAL      = 5'd10,
    S_JALR     = 5'd11,
    S_LUI      = 5'd12,
    S_AUIPC    = 5'd13,
`ifdef RV32M_EN
    S_EXECM    = 5'd14,
`endif
    S_TRAP     = 5'd15
  } state_t;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Request from the FSM to the ALU sub-decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Result mux selects.
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;

  // ALU operand selects.
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  // States that own the memory port and are subject to the wait/timeout rule.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU sub-decoder: maps ALUOp plus funct fields to an ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mc_alu_decoder
  import rv_mc_pkg::*;
(
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] alu_op_i,
  output logic [3:0] alu_ctrl_o
);

  // Fixed add/sub requests pass straight through; otherwise decode funct3/funct7.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // Only register-register ops use funct7b5 for sub; addi never subtracts.
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (fetch/decode/execute/mem/writeback), optional RV32M_EN multiply wait state.
// Latency: 3-5 states per instruction plus memory wait cycles; outputs combinational from state and inputs.
// Backpressure: stalls in memory states until mem_ready, traps after MEM_TIMEOUT waits; EXECM stalls until mul_done.
module multicycle_controller
  import rv_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       Zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       mul_start,
  output logic       trap,
  output logic [4:0] state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_state;
  logic             timeout;
  logic             mem_done;
  logic             br_take;
  logic [1:0]       alu_op;

  // A timeout wins over a late mem_ready, so completion is qualified by !timeout.
  assign mem_state = is_mem_state(state_q);
  assign timeout   = mem_state && (cnt_q == CNT_W'(MEM_TIMEOUT));
  assign mem_done  = mem_state && mem_ready && !timeout;
  assign state_o   = state_q;

  // Branch condition from the ALU flags; reserved funct3 encodings never take.
  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = !Zero;
      3'b100:  br_take = lt;
      3'b101:  br_take = !lt;
      3'b110:  br_take = ltu;
      3'b111:  br_take = !ltu;
      default: br_take = 1'b0;
    endcase
  end

  // Next state and wait counter; the counter only runs while a memory state is stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (timeout) begin
          state_d = S_TRAP;
        end else if (mem_ready) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      // op[5] separates stores (0100011) from loads (0000011).
      S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMWB:  state_d = S_FETCH;
`ifdef RV32M_EN
      S_EXECR:  state_d = funct7b0 ? S_EXECM : S_ALUWB;
      S_EXECM:  state_d = mul_done ? S_ALUWB : S_EXECM;
`else
      S_EXECR:  state_d = S_ALUWB;
`endif
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_FETCH;
      // JALR has already redirected the PC; JAL re-writes the same target and forms OldPC + 4.
      S_JAL:    state_d = S_ALUWB;
      S_JALR:   state_d = S_JAL;
      S_LUI:    state_d = S_FETCH;
      S_AUIPC:  state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

`ifdef RV32M_EN
  logic mul_first_q;
`endif

  // State, wait counter and multiplier entry flag; synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
`ifdef RV32M_EN
      mul_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef RV32M_EN
      mul_first_q <= (state_q == S_EXECR) && funct7b0;
`endif
    end
  end

`ifdef RV32M_EN
  assign mul_start = (state_q == S_EXECM) && mul_first_q;
`else
  assign mul_start = 1'b0;
  logic unused_m;
  assign unused_m = funct7b0 | mul_done;
`endif

  // Datapath controls: Moore decode per state, with write enables qualified by handshake/branch outcome.
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_done;
        PCWrite   = mem_done;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ImmSrc  = IMM_B;
        alu_op  = ALUOP_SUB;
        PCWrite = br_take;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        ImmSrc    = IMM_U;
        RegWrite  = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
`ifdef RV32M_EN
      S_EXECM: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
      end
`endif
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .op5_i      (op[5]),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_op_i   (alu_op),
    .alu_ctrl_o (ALUControl)
  );

endmodule
